// File: rtl/signed_div_if.sv
// signed_div_if: operand/result valid-ready handshake bundle for the signed divide sequencer.
interface signed_div_if #(parameter int DATA_W = 4);
  logic in_valid, in_ready;
  logic [DATA_W-1:0] in_x, in_y;
  logic out_valid, out_ready;
  logic [DATA_W-1:0] out_q, out_r;
  logic out_dz, out_ovf;
  modport master (
    output in_valid, in_x, in_y, out_ready,
    input in_ready, out_valid, out_q, out_r, out_dz, out_ovf
  );
  modport slave (
    input in_valid, in_x, in_y, out_ready,
    output in_ready, out_valid, out_q, out_r, out_dz, out_ovf
  );
endinterface

// File: rtl/signed_div_sequencer.sv
// signed_div_sequencer: signed front/back end around an unsigned combinational divider core,
// with divide-by-zero and most-negative/-1 overflow resolved without the core.
module signed_div_sequencer #(
  parameter int DATA_W = 4,
  parameter int WAIT_CYCLES = 1
) (
  input logic clk,
  input logic rst,
  signed_div_if.slave bus,
  output logic [DATA_W-1:0] core_x,
  output logic [DATA_W-1:0] core_y,
  input logic [DATA_W-1:0] core_q,
  input logic [DATA_W:0] core_r
);
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, WAIT, FIX, OUT} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt;
  logic sx, sy;
  logic [DATA_W-1:0] qm, rm;
  logic dz_c, ovf_c, done_wait;
  assign dz_c = bus.in_y == '0;
  assign ovf_c = bus.in_x == MOST_NEG && bus.in_y == '1;
  assign done_wait = cnt == 4'(WAIT_CYCLES - 1);
  always_comb begin
    state_nxt = state;
    bus.in_ready = state == IDLE;
    bus.out_valid = state == OUT;
    case (state)
      IDLE: state_nxt = bus.in_valid ? ((dz_c || ovf_c) ? OUT : WAIT) : IDLE;
      WAIT: state_nxt = done_wait ? FIX : WAIT;
      FIX: state_nxt = OUT;
      OUT: state_nxt = bus.out_ready ? IDLE : OUT;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // Result registers only move on accept (bypass) or in FIX, so they stay frozen in OUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sx <= 1'b0;
      sy <= 1'b0;
      qm <= '0;
      rm <= '0;
      core_x <= '0;
      core_y <= '0;
      bus.out_q <= '0;
      bus.out_r <= '0;
      bus.out_dz <= 1'b0;
      bus.out_ovf <= 1'b0;
    end else begin
      case (state)
        IDLE:
          if (bus.in_valid) begin
            sx <= bus.in_x[DATA_W-1];
            sy <= bus.in_y[DATA_W-1];
            bus.out_dz <= dz_c;
            bus.out_ovf <= !dz_c && ovf_c;
            if (dz_c) begin
              bus.out_q <= '1;
              bus.out_r <= bus.in_x;
            end else if (ovf_c) begin
              bus.out_q <= MOST_NEG;
              bus.out_r <= '0;
            end else begin
              core_x <= bus.in_x[DATA_W-1] ? -bus.in_x : bus.in_x;
              core_y <= bus.in_y[DATA_W-1] ? -bus.in_y : bus.in_y;
              cnt <= '0;
            end
          end
        WAIT: begin
          cnt <= cnt + 4'd1;
          if (done_wait) begin
            qm <= core_q;
            rm <= core_r[DATA_W-1:0];
          end
        end
        FIX: begin
          bus.out_q <= (sx ^ sy) ? -qm : qm;
          bus.out_r <= sx ? -rm : rm;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_signed_div_sequencer.sv
// tb_signed_div_sequencer: table, hand-written and random checks of two sequencer instances
// (settle time 1 and 4) against a signed-arithmetic reference and behavioural divider cores.
module tb_signed_div_sequencer;
  logic clk, rst;
  logic iv[2], ordy[2], ir[2], ov[2], odz[2], oovf[2];
  logic [3:0] ix[2], iy[2], oq[2], orr[2], cx[2], cy[2], cq[2];
  logic [4:0] cr[2];
  int total, passed;

  signed_div_if #(.DATA_W(4)) bus0 ();
  signed_div_if #(.DATA_W(4)) bus1 ();

  assign bus0.in_valid = iv[0];
  assign bus0.in_x = ix[0];
  assign bus0.in_y = iy[0];
  assign bus0.out_ready = ordy[0];
  assign bus1.in_valid = iv[1];
  assign bus1.in_x = ix[1];
  assign bus1.in_y = iy[1];
  assign bus1.out_ready = ordy[1];
  assign ir[0] = bus0.in_ready;
  assign ov[0] = bus0.out_valid;
  assign oq[0] = bus0.out_q;
  assign orr[0] = bus0.out_r;
  assign odz[0] = bus0.out_dz;
  assign oovf[0] = bus0.out_ovf;
  assign ir[1] = bus1.in_ready;
  assign ov[1] = bus1.out_valid;
  assign oq[1] = bus1.out_q;
  assign orr[1] = bus1.out_r;
  assign odz[1] = bus1.out_dz;
  assign oovf[1] = bus1.out_ovf;

  signed_div_sequencer #(.DATA_W(4), .WAIT_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .core_x(cx[0]), .core_y(cy[0]), .core_q(cq[0]), .core_r(cr[0])
  );
  signed_div_sequencer #(.DATA_W(4), .WAIT_CYCLES(4)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .core_x(cx[1]), .core_y(cy[1]), .core_q(cq[1]), .core_r(cr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core 0: ideal combinational divider; bit 4 of the remainder is junk that must be ignored.
  always_comb begin
    cq[0] = cy[0] == 4'd0 ? 4'd0 : cx[0] / cy[0];
    cr[0] = {1'b1, (cy[0] == 4'd0 ? 4'd0 : cx[0] % cy[0])};
  end

  // Core 1: outputs are inverted garbage until inputs have been stable for 3 full cycles.
  logic [3:0] lx, ly;
  int age, stable;
  always @(posedge clk) begin
    age <= ({cx[1], cy[1]} != {lx, ly}) ? 1 : (age < 15 ? age + 1 : age);
    lx <= cx[1];
    ly <= cy[1];
  end
  always_comb begin
    stable = ({cx[1], cy[1]} == {lx, ly}) ? age : 0;
    cq[1] = cy[1] == 4'd0 ? 4'd0 : cx[1] / cy[1];
    cr[1] = {1'b0, (cy[1] == 4'd0 ? 4'd0 : cx[1] % cy[1])};
    if (stable < 3) begin
      cq[1] = ~cq[1];
      cr[1] = ~cr[1];
    end
  end

  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", n, act, exp);
  endtask

  function automatic void ref_div(input logic [3:0] x, input logic [3:0] y,
      output logic [3:0] q, output logic [3:0] r, output logic dz, output logic ovf);
    int xi, yi;
    xi = $signed(x);
    yi = $signed(y);
    dz = 1'b0;
    ovf = 1'b0;
    if (yi == 0) begin
      q = 4'hF; r = x; dz = 1'b1;
    end else if (xi == -8 && yi == -1) begin
      q = 4'h8; r = 4'h0; ovf = 1'b1;
    end else begin
      q = 4'(xi / yi); r = 4'(xi % yi);
    end
  endfunction

  function automatic logic [3:0] mag(input logic [3:0] v);
    int vi;
    vi = $signed(v);
    return 4'(vi < 0 ? -vi : vi);
  endfunction

  // Called at a negedge; returns at the negedge where out_valid is first seen.
  task automatic op(input int d, input logic [3:0] x, input logic [3:0] y, output int lat);
    int k;
    k = 0;
    while (!ir[d] && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!ir[d]) chk("in_ready_timeout", 0, 1);
    iv[d] = 1'b1;
    ix[d] = x;
    iy[d] = y;
    @(posedge clk);
    @(negedge clk);
    iv[d] = 1'b0;
    lat = 1;
    while (!ov[d] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_op(input int d, input logic [3:0] x, input logic [3:0] y, input string n);
    logic [3:0] eq, er;
    logic edz, eovf;
    int lat, w;
    w = d ? 4 : 1;
    ref_div(x, y, eq, er, edz, eovf);
    op(d, x, y, lat);
    chk({n, "_lat"}, lat, (edz || eovf) ? 1 : w + 2);
    chk({n, "_q"}, oq[d], eq);
    chk({n, "_r"}, orr[d], er);
    chk({n, "_flags"}, {odz[d], oovf[d]}, {edz, eovf});
  endtask

  typedef struct {
    logic [3:0] x, y, q, r;
    logic dz, ovf;
  } vec_t;
  vec_t tbl[12];

  initial begin
    int lat, seen;
    logic [3:0] pcx, pcy, hq, hr;
    tbl[0] = '{4'h7, 4'h2, 4'h3, 4'h1, 1'b0, 1'b0};
    tbl[1] = '{4'h9, 4'h2, 4'hD, 4'hF, 1'b0, 1'b0};
    tbl[2] = '{4'h7, 4'hE, 4'hD, 4'h1, 1'b0, 1'b0};
    tbl[3] = '{4'h7, 4'h0, 4'hF, 4'h7, 1'b1, 1'b0};
    tbl[4] = '{4'h8, 4'hF, 4'h8, 4'h0, 1'b0, 1'b1};
    tbl[5] = '{4'h8, 4'h2, 4'hC, 4'h0, 1'b0, 1'b0};
    tbl[6] = '{4'h6, 4'h3, 4'h2, 4'h0, 1'b0, 1'b0};
    tbl[7] = '{4'h8, 4'h1, 4'h8, 4'h0, 1'b0, 1'b0};
    tbl[8] = '{4'h1, 4'h8, 4'h0, 4'h1, 1'b0, 1'b0};
    tbl[9] = '{4'h9, 4'hF, 4'h7, 4'h0, 1'b0, 1'b0};
    tbl[10] = '{4'h8, 4'h0, 4'hF, 4'h8, 1'b1, 1'b0};
    tbl[11] = '{4'hB, 4'hD, 4'h1, 4'hE, 1'b0, 1'b0};
    total = 0;
    passed = 0;
    rst = 1'b1;
    iv = '{default: 1'b0};
    ordy = '{default: 1'b1};
    ix = '{default: 4'h0};
    iy = '{default: 4'h0};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", ir[0], 1);
    chk("rst_out_valid", ov[0], 0);
    chk("rst_out_qr", {oq[0], orr[0]}, 0);
    chk("rst_flags", {odz[0], oovf[0]}, 0);
    chk("rst_core", {cx[0], cy[0]}, 0);

    foreach (tbl[i]) begin
      pcx = cx[0];
      pcy = cy[0];
      op(0, tbl[i].x, tbl[i].y, lat);
      chk($sformatf("tbl%0d_lat", i), lat, (tbl[i].dz || tbl[i].ovf) ? 1 : 3);
      chk($sformatf("tbl%0d_q", i), oq[0], tbl[i].q);
      chk($sformatf("tbl%0d_r", i), orr[0], tbl[i].r);
      chk($sformatf("tbl%0d_flags", i), {odz[0], oovf[0]}, {tbl[i].dz, tbl[i].ovf});
      chk($sformatf("tbl%0d_core", i), {cx[0], cy[0]},
          (tbl[i].dz || tbl[i].ovf) ? {pcx, pcy} : {mag(tbl[i].x), mag(tbl[i].y)});
    end

    // Backpressure: -6/3 held in OUT while a new pair waits on in_valid.
    @(negedge clk);
    ordy[0] = 1'b0;
    op(0, 4'hA, 4'h3, lat);
    iv[0] = 1'b1;
    ix[0] = 4'h5;
    iy[0] = 4'h2;
    hq = oq[0];
    hr = orr[0];
    chk("bp_q", hq, 4'hE);
    chk("bp_r", hr, 4'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", k), {ov[0], ir[0], oq[0], orr[0]}, {1'b1, 1'b0, hq, hr});
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    chk("bp_release", {ov[0], ir[0]}, {1'b0, 1'b1});
    @(negedge clk);
    iv[0] = 1'b0;
    chk("bp_accept", ir[0], 0);
    lat = 1;
    while (!ov[0] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_next_lat", lat, 3);
    chk("bp_next_qr", {oq[0], orr[0]}, {4'h2, 4'h1});

    repeat (60) begin
      logic [3:0] rx, ry;
      rx = 4'($urandom_range(0, 15));
      ry = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) begin
        rx = 4'h8;
        ry = 4'hF;
      end
      @(negedge clk);
      check_op(0, rx, ry, $sformatf("rnd0_%0h_%0h", rx, ry));
    end

    // Asynchronous reset in the middle of a 4-cycle settle.
    @(negedge clk);
    check_op(1, 4'h7, 4'h2, "w4_first");
    @(negedge clk);
    while (!ir[1]) @(negedge clk);
    iv[1] = 1'b1;
    ix[1] = 4'h5;
    iy[1] = 4'h1;
    @(posedge clk);
    @(negedge clk);
    iv[1] = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", ov[1], 0);
    chk("arst_in_ready", ir[1], 1);
    chk("arst_core", {cx[1], cy[1]}, 0);
    chk("arst_out", {oq[1], orr[1], odz[1], oovf[1]}, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (ov[1]) seen = 1;
    end
    chk("arst_no_result", seen, 0);
    check_op(1, 4'h6, 4'h3, "w4_after_rst");
    repeat (15) begin
      logic [3:0] rx, ry;
      rx = 4'($urandom_range(0, 15));
      ry = 4'($urandom_range(0, 15));
      @(negedge clk);
      check_op(1, rx, ry, $sformatf("rnd1_%0h_%0h", rx, ry));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
